// File: rtl/qsp_issue_scoreboard_if.sv
// ---------------------------------------------------------------------------
// qsp_issue_scoreboard_if
//   Decode -> issue handshake bundle for the QSP issue stage.
//
//   Handshake: the decoder (master) presents an instruction with dec_valid=1
//   and holds every dec_* field stable until it sees dec_ready=1 in the same
//   cycle; that cycle is the transfer. dec_ready is computed by the issue
//   stage (slave) without looking at dec_valid, so it may be high while no
//   instruction is offered.
//
//   Parameters
//     DATA_WIDTH  width of the extended immediate
//     OP_W        width of the ALU operation code
//
//   Signals
//     dec_valid     master -> slave  instruction present
//     dec_ready     slave  -> master instruction accepted when dec_valid=1
//     dec_alu_op    master -> slave  decoded ALU operation
//     dec_rd_addr   master -> slave  destination register
//     dec_we        master -> slave  instruction writes rd
//     dec_rs1_addr  master -> slave  source register 1
//     dec_rs2_addr  master -> slave  source register 2
//     dec_imm_ext   master -> slave  extended immediate
//     dec_use_imm   master -> slave  operand B is the immediate
// ---------------------------------------------------------------------------
interface qsp_issue_scoreboard_if #(
   parameter int DATA_WIDTH = 32,
   parameter int OP_W       = 4
);
   logic                  dec_valid;
   logic                  dec_ready;
   logic [OP_W-1:0]       dec_alu_op;
   logic [3:0]            dec_rd_addr;
   logic                  dec_we;
   logic [3:0]            dec_rs1_addr;
   logic [3:0]            dec_rs2_addr;
   logic [DATA_WIDTH-1:0] dec_imm_ext;
   logic                  dec_use_imm;

   modport master (
      output dec_valid,
      output dec_alu_op,
      output dec_rd_addr,
      output dec_we,
      output dec_rs1_addr,
      output dec_rs2_addr,
      output dec_imm_ext,
      output dec_use_imm,
      input  dec_ready
   );

   modport slave (
      input  dec_valid,
      input  dec_alu_op,
      input  dec_rd_addr,
      input  dec_we,
      input  dec_rs1_addr,
      input  dec_rs2_addr,
      input  dec_imm_ext,
      input  dec_use_imm,
      output dec_ready
   );
endinterface

// File: rtl/qsp_issue_scoreboard.sv
// ---------------------------------------------------------------------------
// qspa_pkg
//   Shared QSP core constants: datapath width and the ALU operation codes.
// ---------------------------------------------------------------------------
package qspa_pkg;
   localparam int DATA_WIDTH = 32;

   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,
      OP_ADD   = 4'd1,
      OP_SUB   = 4'd2,
      OP_AND   = 4'd3,
      OP_OR    = 4'd4,
      OP_XOR   = 4'd5,
      OP_SLL   = 4'd6,
      OP_SRL   = 4'd7,
      OP_SRA   = 4'd8,
      OP_SLT   = 4'd9,
      OP_SLTU  = 4'd10,
      OP_PASSB = 4'd11
   } op_t;
endpackage

// ---------------------------------------------------------------------------
// qsp_issue_scoreboard
//   Issue stage of the QSP core, i.e. the producer side of the ISS->EX
//   pipeline register. Accepts decoded instructions over the dec interface,
//   reads register-file operands, tracks in-flight destination registers in
//   a 16-entry pending bitmap and stalls on RAW/WAW hazards. When nothing
//   issues it drives a NOP bubble (all iss_* zero, iss_alu_op = OP_NOP).
//
//   Build option
//     QSP_ISS_FWD_EN  when defined, a writeback in the current cycle is
//                     bypassed straight into the issued operands, so a
//                     consumer issues in the writeback cycle. When undefined
//                     the consumer issues one cycle later and reads the
//                     already-updated register file.
//
//   Parameters
//     CNT_W  width of the saturating stall counter
//
//   Ports
//     clk, rst_n        clock, asynchronous active-low reset
//     dec               decode handshake (slave side)
//     rf_rs1/2_addr     register-file read addresses (= dec source fields)
//     rf_rs1/2_data     register-file read data (combinational)
//     wb_we/rd/data     writeback port
//     ex_hold/ex_flush  ISS->EX register stall / flush
//     iss_*             fields captured by the ISS->EX register
//     sb_pending        pending bitmap, bit n = write to r<n> in flight
//     stall_cnt         cycles with dec_valid=1 and dec_ready=0 (saturating)
//     dbg_last_rd/we    destination / write-enable of the instruction in EX
// ---------------------------------------------------------------------------
module qsp_issue_scoreboard
   import qspa_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,

   qsp_issue_scoreboard_if.slave dec,

   output logic [3:0]            rf_rs1_addr,
   output logic [3:0]            rf_rs2_addr,
   input  logic [DATA_WIDTH-1:0] rf_rs1_data,
   input  logic [DATA_WIDTH-1:0] rf_rs2_data,

   input  logic                  wb_we,
   input  logic [3:0]            wb_rd_addr,
   input  logic [DATA_WIDTH-1:0] wb_data,

   input  logic                  ex_hold,
   input  logic                  ex_flush,

   output op_t                   iss_alu_op,
   output logic [3:0]            iss_rd_addr,
   output logic                  iss_we,
   output logic [DATA_WIDTH-1:0] iss_imm_ext,
   output logic                  iss_use_imm,
   output logic [DATA_WIDTH-1:0] iss_rs1_data,
   output logic [DATA_WIDTH-1:0] iss_rs2_data,
   output logic [3:0]            iss_rs1_addr,
   output logic [3:0]            iss_rs2_addr,

   output logic [15:0]           sb_pending,
   output logic [CNT_W-1:0]      stall_cnt,

   output logic [3:0]            dbg_last_rd,
   output logic                  dbg_last_we
);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [15:0]      sb_pending_q, sb_pending_d;
   logic [3:0]       last_rd_q,    last_rd_d;
   logic             last_we_q,    last_we_d;
   logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;

   // ------------------------------------------------------------------------
   // Hazard detection and handshake
   // ------------------------------------------------------------------------
   logic byp1;
   logic byp2;
   logic wb_hits_rd;
   logic haz_rs1;
   logic haz_rs2;
   logic haz_rd;
   logic hazard;
   logic ready;
   logic fire;

   always_comb begin
      byp1 = 1'b0;
      byp2 = 1'b0;
`ifdef QSP_ISS_FWD_EN
      byp1 = wb_we && (wb_rd_addr == dec.dec_rs1_addr);
      byp2 = wb_we && (wb_rd_addr == dec.dec_rs2_addr);
`endif
      // A writeback to rd releases the WAW stall in every build: the set of
      // the new pending bit wins over the clear at the same edge, so the
      // ordering of the two writes to rd is preserved without a bypass.
      wb_hits_rd = wb_we && (wb_rd_addr == dec.dec_rd_addr);

      haz_rs1 = sb_pending_q[dec.dec_rs1_addr] && !byp1;
      haz_rs2 = !dec.dec_use_imm && sb_pending_q[dec.dec_rs2_addr] && !byp2;
      haz_rd  = dec.dec_we && sb_pending_q[dec.dec_rd_addr] && !wb_hits_rd;
      hazard  = haz_rs1 || haz_rs2 || haz_rd;

      // ready does not depend on dec_valid, keeping the handshake free of
      // combinational loops through the decoder.
      ready = !hazard && !ex_hold && !ex_flush;
      fire  = dec.dec_valid && ready;
   end

   assign dec.dec_ready = ready;

   assign rf_rs1_addr = dec.dec_rs1_addr;
   assign rf_rs2_addr = dec.dec_rs2_addr;

   // ------------------------------------------------------------------------
   // Issue fields: either the accepted instruction or a NOP bubble
   // ------------------------------------------------------------------------
   always_comb begin
      iss_alu_op   = OP_NOP;
      iss_rd_addr  = '0;
      iss_we       = 1'b0;
      iss_imm_ext  = '0;
      iss_use_imm  = 1'b0;
      iss_rs1_data = '0;
      iss_rs2_data = '0;
      iss_rs1_addr = '0;
      iss_rs2_addr = '0;
      if (fire) begin
         iss_alu_op   = op_t'(dec.dec_alu_op);
         iss_rd_addr  = dec.dec_rd_addr;
         iss_we       = dec.dec_we;
         iss_imm_ext  = dec.dec_imm_ext;
         iss_use_imm  = dec.dec_use_imm;
         iss_rs1_data = byp1 ? wb_data : rf_rs1_data;
         iss_rs2_data = byp2 ? wb_data : rf_rs2_data;
         iss_rs1_addr = dec.dec_rs1_addr;
         iss_rs2_addr = dec.dec_rs2_addr;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state: pending bitmap, EX tracking, stall counter
   // ------------------------------------------------------------------------
   always_comb begin
      sb_pending_d = sb_pending_q;
      // Writeback of a register that is not pending is legal and harmless.
      if (wb_we) begin
         sb_pending_d[wb_rd_addr] = 1'b0;
      end
      // The instruction being flushed out of EX will never write back, so
      // its pending bit has to be dropped here or its readers deadlock.
      if (ex_flush && last_we_q) begin
         sb_pending_d[last_rd_q] = 1'b0;
      end
      // Applied last so a new writer wins over a same-cycle clear.
      if (fire && dec.dec_we) begin
         sb_pending_d[dec.dec_rd_addr] = 1'b1;
      end
   end

   // last_rd/last_we follow the ISS->EX register: flush beats hold.
   always_comb begin
      last_rd_d = last_rd_q;
      last_we_d = last_we_q;
      if (ex_flush) begin
         last_we_d = 1'b0;
      end else if (!ex_hold) begin
         last_we_d = fire && dec.dec_we;
         last_rd_d = dec.dec_rd_addr;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (dec.dec_valid && !ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb_pending_q <= '0;
         last_rd_q    <= '0;
         last_we_q    <= 1'b0;
         stall_cnt_q  <= '0;
      end else begin
         sb_pending_q <= sb_pending_d;
         last_rd_q    <= last_rd_d;
         last_we_q    <= last_we_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign sb_pending  = sb_pending_q;
   assign stall_cnt   = stall_cnt_q;
   assign dbg_last_rd = last_rd_q;
   assign dbg_last_we = last_we_q;

endmodule
